pe_id_config_loader: RTL
========================

// Module: pe_id_config_loader
// PURPOSE
//  Transmit side of the PE-array ID configuration path. Snapshots the combinational ID tables (filter/ifmap/ipsum/opsum
//  X/Y IDs + LN_config) on start and serialises them over a valid/ready config bus into the per-row Y-bus and per-PE
//  X-bus multicast-controller ID registers. Sits between the layer controller and the PE array config ports.
// PARAMETERS
//  NUM_ROW  6   PE array rows (Y-bus count per data type)
//  NUM_COL  8   PE array columns (NUM_ROW*NUM_COL = 48 X-bus MCs per data type)
//  XID_W    5   X-bus ID width; all-ones (31) = MC disabled
//  YID_W    3   Y-bus ID width; all-ones (7)  = MC disabled
// PORTS
//  clk            in   1                    clock, rising edge
//  rst            in   1                    asynchronous, active-high reset
//  start          in   1                    1-cycle request; sampled only in IDLE
//  abort          in   1                    synchronous cancel of an in-flight load
//  xid_flat       in   4*NUM_ROW*NUM_COL*XID_W  X IDs, type t (0 filter,1 ifmap,2 ipsum,3 opsum), PE idx = row*NUM_COL+col
//  yid_flat       in   4*NUM_ROW*YID_W      Y IDs, type t, row r
//  ln_config      in   5                    LN_config word from the ID generator
//  cfg_valid      out  1                    config word valid
//  cfg_ready      in   1                    array accepts word this cycle
//  cfg_type       out  2                    data type of current word
//  cfg_is_y       out  1                    1 = Y-bus ID, 0 = X-bus ID
//  cfg_row        out  3                    target row
//  cfg_col        out  3                    target column (0 when cfg_is_y)
//  cfg_id         out  5                    ID value (YID zero-extended to 5 bits)
//  ln_we          out  1                    1-cycle write strobe for ln_out
//  ln_out         out  5                    registered LN_config
//  busy           out  1                    high from the cycle after start until done/abort
//  done           out  1                    1-cycle pulse after final transfer
// BEHAVIOUR
//  Reset: state IDLE; cfg_valid, ln_we, busy, done = 0; cfg_type/is_y/row/col/id = 0; ln_out = 0; snapshot regs = 0.
//  FSM: IDLE -> LOAD_Y (start) -> LOAD_X -> (next type: LOAD_Y | after type 3: LOAD_LN) -> FIN -> IDLE.
//   IDLE: on start latch xid_flat, yid_flat, ln_config into snapshot; type=0,row=0,col=0. start in any other state ignored.
//   LOAD_Y: send Y word rows 0..NUM_ROW-1 for current type.
//   LOAD_X: send X words row-major (col fastest) 0..NUM_ROW*NUM_COL-1 for current type; then type+1.
//   LOAD_LN: single cycle, ln_we=1, ln_out=snapshot LN (no handshake). FIN: done=1 one cycle, busy drops with it.
//  Handshake: word transfers on cfg_valid & cfg_ready; cfg_valid stays high with payload stable until accepted;
//   counters advance only on transfer; next word presented the cycle after transfer (zero-bubble under ready=1).
//  Latency: start in cycle N -> first word (type0, Y, row0) valid in N+1. With cfg_ready tied high:
//   4*(NUM_ROW+NUM_ROW*NUM_COL)=216 words in N+1..N+216, ln_we at N+217, done at N+218.
//  Disabled IDs (31/7) are transmitted like any other value; loader never skips entries.
//  abort: in any non-IDLE state -> IDLE next cycle, cfg_valid=0, busy=0, no done, no ln_we; abort in IDLE no-op.
//   abort and cfg_ready on same cycle: transfer counts at the receiver, loader still goes IDLE.
//  Snapshot isolation: input tables changing while busy have no effect on transmitted words.
//  Async rst mid-load: immediate return to reset values; next start restarts from type0 row0.
//  Counter widths: row 3b, col 3b, type 2b; type wrap 3->0 is not used (LOAD_LN taken instead).
// STRUCTURE
//  Shared package: localparams XID_OFF=5'd31, YID_OFF=3'd7, type codes TYPE_FILTER..TYPE_OPSUM, FSM state enum,
//   NUM_ID_TYPES=4. Single module; entry mux (type,row,col -> id) is an inline function, no sub-module needed.
// TESTING
//  1 ready=1, start with table xid[t][i]=(t*8+i)%31, yid[t][r]=r -> 216 words in order, ids match, done at N+218.
//  2 ready toggled pseudo-randomly (50%) -> identical word sequence, payload stable while valid&!ready, no drops/dups.
//  3 change xid_flat/ln_config after start -> transmitted values equal the start-cycle snapshot; ln_out=snapshot.
//  4 abort at word 100 (type1 X) -> cfg_valid=0 next cycle, busy=0, done never pulses; restart sends type0 row0 first.
//  5 start pulsed again while busy, and start concurrent with done -> ignored; only one 216-word sequence per accepted start.
//  6 async rst asserted mid-LOAD_X then released -> all outputs at reset values immediately; fresh start completes normally.

Source files
------------

// File: rtl/pe_id_config_loader_pkg.sv
// Shared types and constants for the PE-array ID configuration loader.
// Holds the data-type codes, the disabled-ID values and the loader FSM states.
package pe_id_config_loader_pkg;

  localparam int NUM_ID_TYPES = 4;
  localparam int TYPE_W       = 2;
  localparam int ROW_W        = 3;
  localparam int COL_W        = 3;
  localparam int ID_W         = 5;
  localparam int LN_W         = 5;

  // All-ones IDs mark a disabled multicast controller; they are sent like any other value.
  localparam logic [4:0] XID_OFF = 5'd31;
  localparam logic [2:0] YID_OFF = 3'd7;

  localparam logic [TYPE_W-1:0] TYPE_FILTER = 2'd0;
  localparam logic [TYPE_W-1:0] TYPE_IFMAP  = 2'd1;
  localparam logic [TYPE_W-1:0] TYPE_IPSUM  = 2'd2;
  localparam logic [TYPE_W-1:0] TYPE_OPSUM  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Y,
    S_LOAD_X,
    S_LOAD_LN,
    S_FIN
  } state_t;

endpackage

// File: rtl/pe_id_config_loader_if.sv
// Valid/ready config bus carrying one multicast-controller ID per transfer.
interface pe_id_config_loader_if;
  import pe_id_config_loader_pkg::*;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [TYPE_W-1:0] cfg_type;
  logic              cfg_is_y;
  logic [ROW_W-1:0]  cfg_row;
  logic [COL_W-1:0]  cfg_col;
  logic [ID_W-1:0]   cfg_id;

  modport master (
    output cfg_valid, cfg_type, cfg_is_y, cfg_row, cfg_col, cfg_id,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_type, cfg_is_y, cfg_row, cfg_col, cfg_id,
    output cfg_ready
  );

endinterface

// File: rtl/pe_id_config_loader.sv
// Snapshots the X/Y ID tables and LN_config on start, then serialises every Y and X
// multicast-controller ID over the config bus, type by type, followed by one LN write.
module pe_id_config_loader
  import pe_id_config_loader_pkg::*;
#(
  parameter int NUM_ROW = 6,
  parameter int NUM_COL = 8,
  parameter int XID_W   = 5,
  parameter int YID_W   = 3
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic                                       abort,
  input  logic [NUM_ID_TYPES*NUM_ROW*NUM_COL*XID_W-1:0] xid_flat,
  input  logic [NUM_ID_TYPES*NUM_ROW*YID_W-1:0]      yid_flat,
  input  logic [LN_W-1:0]                            ln_config,
  pe_id_config_loader_if.master                      cfg,
  output logic                                       ln_we,
  output logic [LN_W-1:0]                            ln_out,
  output logic                                       busy,
  output logic                                       done
);

  localparam int XTAB_W = NUM_ID_TYPES * NUM_ROW * NUM_COL * XID_W;
  localparam int YTAB_W = NUM_ID_TYPES * NUM_ROW * YID_W;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROW - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COL - 1);

  state_t             state, state_nxt;
  logic [TYPE_W-1:0]  type_q, type_nxt;
  logic [ROW_W-1:0]   row_q, row_nxt;
  logic [COL_W-1:0]   col_q, col_nxt;
  logic [XTAB_W-1:0]  xid_snap;
  logic [YTAB_W-1:0]  yid_snap;
  logic [LN_W-1:0]    ln_snap;
  logic               load_st;
  logic               xfer;
  logic               snap_en;
  logic               ln_load;

  // Table entry select: Y tables indexed [type][row], X tables [type][row*NUM_COL+col].
  function automatic logic [ID_W-1:0] entry_id(
    input logic [TYPE_W-1:0] t,
    input logic [ROW_W-1:0]  r,
    input logic [COL_W-1:0]  c,
    input logic              is_y,
    input logic [XTAB_W-1:0] xt,
    input logic [YTAB_W-1:0] yt
  );
    int yi;
    int xi;
    yi = int'(t) * NUM_ROW + int'(r);
    xi = yi * NUM_COL + int'(c);
    if (is_y) return ID_W'(yt[yi*YID_W +: YID_W]);
    return ID_W'(xt[xi*XID_W +: XID_W]);
  endfunction

  assign load_st       = (state == S_LOAD_Y) || (state == S_LOAD_X);
  assign xfer          = load_st && cfg.cfg_ready;
  assign cfg.cfg_valid = load_st;
  assign cfg.cfg_is_y  = (state == S_LOAD_Y);
  assign cfg.cfg_type  = type_q;
  assign cfg.cfg_row   = row_q;
  assign cfg.cfg_col   = cfg.cfg_is_y ? '0 : col_q;
  assign cfg.cfg_id    = entry_id(type_q, row_q, col_q, cfg.cfg_is_y, xid_snap, yid_snap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    type_nxt  = type_q;
    row_nxt   = row_q;
    col_nxt   = col_q;
    snap_en   = 1'b0;
    ln_load   = 1'b0;
    ln_we     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD_Y;
          type_nxt  = TYPE_FILTER;
          row_nxt   = '0;
          col_nxt   = '0;
          snap_en   = 1'b1;
        end
      end
      S_LOAD_Y: begin
        busy = 1'b1;
        if (xfer) begin
          if (row_q == LAST_ROW) begin
            row_nxt   = '0;
            state_nxt = S_LOAD_X;
          end else begin
            row_nxt = row_q + 1'b1;
          end
        end
      end
      S_LOAD_X: begin
        busy = 1'b1;
        if (xfer) begin
          if (col_q != LAST_COL) begin
            col_nxt = col_q + 1'b1;
          end else begin
            col_nxt = '0;
            if (row_q != LAST_ROW) begin
              row_nxt = row_q + 1'b1;
            end else begin
              row_nxt = '0;
              // After the last data type the LN word follows instead of a type wrap.
              if (type_q == TYPE_OPSUM) begin
                type_nxt  = TYPE_FILTER;
                state_nxt = S_LOAD_LN;
                ln_load   = 1'b1;
              end else begin
                type_nxt  = type_q + 1'b1;
                state_nxt = S_LOAD_Y;
              end
            end
          end
        end
      end
      S_LOAD_LN: begin
        busy      = 1'b1;
        ln_we     = 1'b1;
        state_nxt = S_FIN;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A cancelled load must not leave a partial LN write or completion pulse behind.
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
      ln_load   = 1'b0;
      ln_we     = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      type_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      xid_snap <= '0;
      yid_snap <= '0;
      ln_snap  <= '0;
      ln_out   <= '0;
    end else begin
      type_q <= type_nxt;
      row_q  <= row_nxt;
      col_q  <= col_nxt;
      if (snap_en) begin
        xid_snap <= xid_flat;
        yid_snap <= yid_flat;
        ln_snap  <= ln_config;
      end
      if (ln_load) ln_out <= ln_snap;
    end
  end

endmodule
